// File: rtl/ssd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ssd_pkg
// Description : Shared definitions for the 7-segment scan driver. Holds the
//               segment bit positions, the scan FSM state type and the anode
//               one-hot helper.
// Revision    : 1.0 - initial release
// ============================================================================
package ssd_pkg;

  // Segment bit positions within the 7-bit seg bus
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam int MAX_DIGITS = 8;

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_e;

  // One-hot anode vector for digit idx. The caller truncates it to its digit count.
  function automatic logic [MAX_DIGITS-1:0] anode_onehot(input logic [2:0] idx,
                                                         input logic       active_low);
    logic [MAX_DIGITS-1:0] oh;
    oh = MAX_DIGITS'(1) << idx;
    return active_low ? ~oh : oh;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ssd_scan_driver_bin_decoder.sv
`default_nettype none
// ============================================================================
// Module      : SSD_Bin_Decoder
// Description : Hex nibble to 7-segment pattern, 1 = segment lit.
//               Bit order is A..G at bits 0..6.
// Ports       : bin [3:0] - nibble in
//               seg [6:0] - segment pattern out (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module SSD_Bin_Decoder
  import ssd_pkg::*;
(
  input  logic [3:0] bin,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (bin)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ssd_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : ssd_scan_driver
// Description : Time-multiplexed common-anode 7-segment scanner with a
//               double-buffered hex value. Each digit slot is a blank phase
//               (all anodes off) followed by a show phase for one digit.
// Ports       : clk, rst          - clock, async active-high reset
//               value_in, dp_in   - data captured into the shadow on load
//               digit_en          - live per-digit enable
//               load              - single-cycle capture strobe
//               pending           - shadow not yet transferred to display
//               frame_start       - pulse on first blank clock of digit 0
//               an, seg, dp       - registered display drive
// Revision    : 1.0 - initial release
// ============================================================================
module ssd_scan_driver
  import ssd_pkg::*;
#(
  parameter int NUM_DIGITS       = 4,
  parameter int DIGIT_CYCLES     = 100000,
  parameter int BLANK_CYCLES     = 1000,
  parameter bit ANODE_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    load,
  output logic                    pending,
  output logic                    frame_start,
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    dp
);

  localparam int CNT_MAX = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0]      DIGIT_LAST = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [IDX_W-1:0]      IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  // --------------------------------------------------------------------------
  // Scan position. (state_q, idx_q, cnt_q) names the clock that the display
  // outputs will show after the next edge; the output registers are loaded
  // from it. This lets the first clock after reset release already be the
  // first blank clock of digit 0 with frame_start high.
  // --------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BLANK;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + CNT_W'(1);
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          state_d = ST_SHOW;
          cnt_d   = '0;
        end
      end
      ST_SHOW: begin
        if (cnt_q == DIGIT_LAST) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = ST_BLANK;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Shadow / active data buffers
  // --------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic [4*NUM_DIGITS-1:0] active_val_q, active_val_d;
  logic [NUM_DIGITS-1:0]   active_dp_q, active_dp_d;
  logic                    pending_q, pending_d;
  logic                    frame_start_q;

  // Transfer happens at the end of the frame_start clock, before digit 0's
  // show phase is computed, so a frame always displays one consistent value.
  always_comb begin
    shadow_val_d = shadow_val_q;
    shadow_dp_d  = shadow_dp_q;
    active_val_d = active_val_q;
    active_dp_d  = active_dp_q;
    pending_d    = pending_q;
    if (frame_start_q) begin
      if (load) begin
        shadow_val_d = value_in;
        shadow_dp_d  = dp_in;
        active_val_d = value_in;
        active_dp_d  = dp_in;
        pending_d    = 1'b0;
      end else if (pending_q) begin
        active_val_d = shadow_val_q;
        active_dp_d  = shadow_dp_q;
        pending_d    = 1'b0;
      end
    end else if (load) begin
      shadow_val_d = value_in;
      shadow_dp_d  = dp_in;
      pending_d    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val_q <= '0;
      shadow_dp_q  <= '0;
      active_val_q <= '0;
      active_dp_q  <= '0;
      pending_q    <= 1'b0;
    end else begin
      shadow_val_q <= shadow_val_d;
      shadow_dp_q  <= shadow_dp_d;
      active_val_q <= active_val_d;
      active_dp_q  <= active_dp_d;
      pending_q    <= pending_d;
    end
  end

  // --------------------------------------------------------------------------
  // Digit select and decode
  // --------------------------------------------------------------------------
  logic [3:0] nibble_sel;
  logic       dp_sel;
  logic       en_sel;
  logic [6:0] dec_seg;

  always_comb begin
    nibble_sel = 4'h0;
    dp_sel     = 1'b0;
    en_sel     = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        nibble_sel = active_val_q[4*k +: 4];
        dp_sel     = active_dp_q[k];
        en_sel     = digit_en[k];
      end
    end
  end

  SSD_Bin_Decoder u_dec (
    .bin (nibble_sel),
    .seg (dec_seg)
  );

  // --------------------------------------------------------------------------
  // Output decode (registered below so an/seg/dp switch on the same edge)
  // --------------------------------------------------------------------------
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;
  logic                  frame_start_d;

  always_comb begin
    an_d          = AN_OFF;
    seg_d         = 7'h00;
    dp_d          = 1'b0;
    frame_start_d = (state_q == ST_BLANK) && (idx_q == '0) && (cnt_q == '0);
    // A disabled digit keeps its slot time but stays dark.
    if ((state_q == ST_SHOW) && en_sel) begin
      an_d  = NUM_DIGITS'(anode_onehot(3'(idx_q), ANODE_ACTIVE_LOW));
      seg_d = dec_seg;
      dp_d  = dp_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an_q          <= AN_OFF;
      seg_q         <= 7'h00;
      dp_q          <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign frame_start = frame_start_q;
  assign pending     = pending_q;

endmodule
`default_nettype wire
